// File: rtl/pat_pkg.sv
// -----------------------------------------------------------------------------
// pat_pkg
// Shared constants for the PAT port bank: port index map, port 1 status bit
// positions, the minimum port count, and a helper that sizes the ext_* ports.
// -----------------------------------------------------------------------------
package pat_pkg;

  // Port index map
  localparam int unsigned PORT_PADS = 0;
  localparam int unsigned PORT_CTRL = 1;
  localparam int unsigned PORT_EDGE = 2;
  localparam int unsigned PORT_EXT0 = 3;

  // Fewest ports the bank can be built with (ports 0..2 are fixed-function)
  localparam int unsigned MIN_PORTS = 3;

  // Port 1 input status bit positions
  localparam int unsigned CTRL_PWM_LOW   = 0;
  localparam int unsigned CTRL_PWM_HIGH  = 1;
  localparam int unsigned CTRL_EDGE_PEND = 2;

  // Width of the ext_out/ext_in buses. With only the three fixed ports there
  // is nothing to carry, but a port cannot be zero wide, so a 1-bit stub is
  // kept (driven 0 / ignored).
  function automatic int unsigned ext_width(input int unsigned n_ports,
                                            input int unsigned d_width);
    return (n_ports > PORT_EXT0) ? (n_ports - PORT_EXT0) * d_width : 1;
  endfunction

endpackage

// File: rtl/pat_sync_edge.sv
// -----------------------------------------------------------------------------
// pat_sync_edge
// Per-bit two-flop synchroniser for asynchronous pad inputs, plus an optional
// sticky edge flag per bit (set on either edge of the synchronised bit,
// cleared by clr_i; a set in the same cycle as a clear wins).
//
// Build option: PAT_EDGE_DETECT_EN -- when undefined the flag logic is not
// built, flag_o reads 0 and clr_i is ignored. The synchroniser is always built.
//
// Ports:
//   clk_i   system clock
//   rst_ni  asynchronous active-low reset
//   d_i     raw pad inputs [WIDTH]
//   clr_i   clear all edge flags
//   sync_o  synchronised pad value [WIDTH]
//   flag_o  sticky edge flags [WIDTH]
// -----------------------------------------------------------------------------
module pat_sync_edge #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  input  logic             clr_i,
  output logic [WIDTH-1:0] sync_o,
  output logic [WIDTH-1:0] flag_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign sync_o = sync_q;

`ifdef PAT_EDGE_DETECT_EN
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] flag_q;
  logic [WIDTH-1:0] flag_d;

  // Edge is detected on the synchronised value, one cycle after it settles,
  // so the flag becomes visible on the third clock after the pad change.
  always_comb begin
    flag_d = (flag_q & ~{WIDTH{clr_i}}) | (sync_q ^ prev_q);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prev_q <= '0;
      flag_q <= '0;
    end else begin
      prev_q <= sync_q;
      flag_q <= flag_d;
    end
  end

  assign flag_o = flag_q;
`else
  logic unused_clr;
  assign unused_clr = clr_i;
  assign flag_o     = '0;
`endif

endmodule

// File: rtl/pat_port_bank.sv
// -----------------------------------------------------------------------------
// pat_port_bank
// I/O port bank between the PAT core port arrays and the chip pads.
//   Port 0: in = synchronised pads_in,       out = pads_out register (out_wr[0])
//   Port 1: in = {0.., edge_pending, pwm_high, pwm_low}, out = PWM duty shadow
//   Port 2: in = sticky edge flags (in_rd[2] clears), out ignored
//   Port k>=3: in = ext_in slice (combinational), out = ext_out register
// PWM: free-running D_WIDTH-bit counter; duty_active reloads from the shadow
// on the wrap edge, or directly from pat_out[1] when out_wr[1] hits that edge.
//
// Build option: PAT_EDGE_DETECT_EN enables the edge flags / edge_pending.
//
// Ports:
//   clk       system clock
//   reset     asynchronous active-low reset
//   pads_in   raw pad inputs [D_WIDTH]
//   pads_out  pad outputs (port 0) [D_WIDTH]
//   pat_out   PAT output data, port k at [k*D_WIDTH +: D_WIDTH]
//   out_wr    per-port write strobes [N_PORTS]
//   pat_in    PAT input data, same packing as pat_out
//   in_rd     per-port read strobes [N_PORTS]
//   ext_out   ports 3.. outputs (1-bit stub tied 0 when N_PORTS = 3)
//   ext_in    ports 3.. inputs  (1-bit stub ignored when N_PORTS = 3)
//   pwm_high  PWM high-side drive
//   pwm_low   PWM low-side drive, complement of pwm_high
// -----------------------------------------------------------------------------
module pat_port_bank
  import pat_pkg::*;
#(
  parameter int unsigned D_WIDTH = 8,
  parameter int unsigned N_PORTS = 3
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [D_WIDTH-1:0]                     pads_in,
  output logic [D_WIDTH-1:0]                     pads_out,
  input  logic [N_PORTS*D_WIDTH-1:0]             pat_out,
  input  logic [N_PORTS-1:0]                     out_wr,
  output logic [N_PORTS*D_WIDTH-1:0]             pat_in,
  input  logic [N_PORTS-1:0]                     in_rd,
  output logic [ext_width(N_PORTS, D_WIDTH)-1:0] ext_out,
  input  logic [ext_width(N_PORTS, D_WIDTH)-1:0] ext_in,
  output logic                                   pwm_high,
  output logic                                   pwm_low
);

  if (N_PORTS < MIN_PORTS) begin : g_bad_ports
    $error("pat_port_bank: N_PORTS must be at least %0d", MIN_PORTS);
  end

  logic [D_WIDTH-1:0] pads_sync;
  logic [D_WIDTH-1:0] edge_flags;
  logic               edge_pending;
  logic [D_WIDTH-1:0] ctrl_status;
  logic [D_WIDTH-1:0] duty_wdata;
  logic               wrap;

  logic [D_WIDTH-1:0] pads_out_q,    pads_out_d;
  logic [D_WIDTH-1:0] duty_shadow_q, duty_shadow_d;
  logic [D_WIDTH-1:0] duty_active_q, duty_active_d;
  logic [D_WIDTH-1:0] cnt_q,         cnt_d;

  // Strobes/data that have no function on some ports
  logic unused_strobes;
  assign unused_strobes = ^{in_rd, out_wr[PORT_EDGE],
                            pat_out[PORT_EDGE*D_WIDTH +: D_WIDTH]};

  pat_sync_edge #(
    .WIDTH (D_WIDTH)
  ) u_sync_edge (
    .clk_i  (clk),
    .rst_ni (reset),
    .d_i    (pads_in),
    .clr_i  (in_rd[PORT_EDGE]),
    .sync_o (pads_sync),
    .flag_o (edge_flags)
  );

  assign edge_pending = |edge_flags;

  // ---------------------------------------------------------------------------
  // Port 0 output register and PWM
  // ---------------------------------------------------------------------------
  assign duty_wdata = pat_out[PORT_CTRL*D_WIDTH +: D_WIDTH];
  assign wrap       = (cnt_q == '1);

  always_comb begin
    cnt_d         = cnt_q + 1'b1;
    pads_out_d    = out_wr[PORT_PADS] ? pat_out[PORT_PADS*D_WIDTH +: D_WIDTH]
                                      : pads_out_q;
    duty_shadow_d = out_wr[PORT_CTRL] ? duty_wdata : duty_shadow_q;
    duty_active_d = duty_active_q;
    // A write landing on the wrap edge bypasses the shadow so it takes effect
    // in the period that is just starting.
    if (wrap) begin
      duty_active_d = out_wr[PORT_CTRL] ? duty_wdata : duty_shadow_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q         <= '0;
      pads_out_q    <= '0;
      duty_shadow_q <= '0;
      duty_active_q <= '0;
    end else begin
      cnt_q         <= cnt_d;
      pads_out_q    <= pads_out_d;
      duty_shadow_q <= duty_shadow_d;
      duty_active_q <= duty_active_d;
    end
  end

  assign pads_out = pads_out_q;
  assign pwm_high = (cnt_q < duty_active_q);
  assign pwm_low  = ~pwm_high;

  // ---------------------------------------------------------------------------
  // PAT input ports 0..2
  // ---------------------------------------------------------------------------
  always_comb begin
    ctrl_status                 = '0;
    ctrl_status[CTRL_PWM_LOW]   = pwm_low;
    ctrl_status[CTRL_PWM_HIGH]  = pwm_high;
    ctrl_status[CTRL_EDGE_PEND] = edge_pending;
  end

  assign pat_in[PORT_EXT0*D_WIDTH-1:0] = {edge_flags, ctrl_status, pads_sync};

  // ---------------------------------------------------------------------------
  // Extension ports 3..N_PORTS-1
  // ---------------------------------------------------------------------------
  if (N_PORTS > PORT_EXT0) begin : g_ext
    for (genvar k = PORT_EXT0; k < N_PORTS; k++) begin : g_port
      logic [D_WIDTH-1:0] ext_q, ext_d;

      assign ext_d = out_wr[k] ? pat_out[k*D_WIDTH +: D_WIDTH] : ext_q;

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          ext_q <= '0;
        end else begin
          ext_q <= ext_d;
        end
      end

      assign ext_out[(k-PORT_EXT0)*D_WIDTH +: D_WIDTH] = ext_q;
    end

    assign pat_in[N_PORTS*D_WIDTH-1:PORT_EXT0*D_WIDTH] = ext_in;
  end else begin : g_no_ext
    logic unused_ext;
    assign ext_out    = '0;
    assign unused_ext = ^ext_in;
  end

endmodule

// File: doc/pat_port_bank.md
# pat_port_bank

Parametrised I/O port bank between the PAT core's port arrays and the chip pads. Generalises the fixed three-port wiring to N_PORTS ports, and adds behaviour the fixed wiring lacks:
- two-flop pad synchronisation;
- sticky per-bit edge capture with read-to-clear;
- registered, strobed output ports;
- an internal shadow-buffered PWM generator that replaces the external pwm_low/pwm_high pins.

## Interface
Parameters:
- D_WIDTH, 8, port and pad width; also the PWM counter width
- N_PORTS, 3, number of PAT ports; must be ≥ 3

Ports:
- clk  input  1  single system clock
- reset  input  1  active-low, asynchronous reset
- pads_in  input  D_WIDTH  raw asynchronous pad inputs
- pads_out  output  D_WIDTH  pad outputs (port 0)
- pat_out  input  N_PORTS*D_WIDTH  PAT output port data; port k occupies bits [k*D_WIDTH +: D_WIDTH]
- out_wr  input  N_PORTS  per-port write strobe, one cycle
- pat_in  output  N_PORTS*D_WIDTH  PAT input port data, same packing
- in_rd  input  N_PORTS  per-port read strobe, one cycle
- ext_out  output  (N_PORTS-3)*D_WIDTH  ports 3.. outputs; absent when N_PORTS = 3
- ext_in  input  (N_PORTS-3)*D_WIDTH  ports 3.. inputs; absent when N_PORTS = 3
- pwm_high  output  1  PWM high-side drive
- pwm_low  output  1  PWM low-side drive, always the complement of pwm_high

## Operation
Port map:
- Port 0 input = synchronised pads_in. Port 0 output = pads_out register, loaded from pat_out[0] on out_wr[0].
- Port 1 input = {5'b0, edge_pending, pwm_high, pwm_low}; for D_WIDTH > 8, pad the upper bits with 0. Port 1 output: out_wr[1] writes duty_shadow.
- Port 2 input = edge flag register. Port 2 output: out_wr[2] is ignored.
- Port k ≥ 3 input = ext_in slice, passed through combinationally. Port k ≥ 3 output = registered ext_out slice, loaded on out_wr[k].

Edge capture:
- Each pad bit has a flag, set on either edge of the synchronised bit.
- in_rd[2] clears all flags. When a set and a clear occur in the same cycle, the set wins.
- edge_pending = OR of all flags.

PWM:
- cnt is D_WIDTH bits, free-running 0..2^D_WIDTH-1, and wraps to 0.
- pwm_high = (cnt < duty_active); pwm_low = ~pwm_high.
- duty_active loads duty_shadow on the edge where cnt goes from all-ones to 0.
- If out_wr[1] falls on that same edge, pat_out[1] goes straight into duty_active (bypass).
- Duty 0 gives pwm_high always 0. Duty 2^D_WIDTH-1 gives pwm_high 0 for one count per period.

Reset (async assert, synchronous deassert at the top level): all registers clear to 0, including sync flops, flags, pads_out, ext_out, cnt and both duty registers. After reset: pwm_high = 0, pwm_low = 1, pat_in all 0 except port 1 bit 0 = 1. Reset mid-period aborts the PWM period and restarts at cnt = 0 with duty 0.

## Timing
- Pad to port 0 input: 2 clk latency after a pad change meets setup.
- Pad edge to flag set: visible on pat_in[2] 3 clk after the pad change.
- out_wr[k] at edge n: pads_out / ext_out change after edge n.
- out_wr[1] outside the wrap edge: no effect until the next wrap. The worst case is 2^D_WIDTH clk.
- pat_in is combinational from registers and ext_in. The PAT samples it in the same cycle it asserts in_rd.
- Strobes are level-sampled each clk. Holding a strobe for several cycles repeats the write or clear; the result is idempotent.

## Configuration
- PAT_EDGE_DETECT_EN defined: edge flag registers and edge_pending are built as described.
- PAT_EDGE_DETECT_EN undefined: no flag logic is built; pat_in[2] and edge_pending read 0, and in_rd[2] is ignored. The synchronisers remain.

## Structure
- Package pat_pkg holds:
  - port index constants PORT_PADS = 0, PORT_CTRL = 1, PORT_EDGE = 2, PORT_EXT0 = 3
  - port 1 status bit positions
  - the requirement N_PORTS ≥ 3, checked by an elaboration assertion
- One sub-module, pat_sync_edge: per-bit two-flop synchroniser plus sticky edge flag with set-wins clear. Instantiate it D_WIDTH wide.
- The PWM counter and duty registers stay in the top module.

## Test plan
- Reset: assert reset mid-run with cnt = 0x80 and duty_active = 0x40. Required: all outputs 0, pwm_low = 1, cnt = 0 immediately, and no clk edge needed.
- Pad sync and edge: pads_in 0x00 → 0x05. Required: pat_in[0] = 0x05 after 2 clk; pat_in[2] = 0x05 and port 1 bit 2 = 1 after 3 clk. Then in_rd[2] clears the flags to 0x00.
- Set-wins: toggle pads bit 7 so its flag sets in the same cycle as in_rd[2]. Required: pat_in[2] = 0x80 afterwards.
- PWM shadow: write duty 0x40 at cnt = 0x10. Required: the old duty holds until the wrap, then pwm_high is high for exactly 64 of 256 clk per period, with pwm_low its complement throughout.
- Wrap bypass: out_wr[1] = 0xFF on the wrap edge. Required: the very next period has pwm_high for 255 clk. Also duty 0 gives pwm_high never set.
- N_PORTS = 5: write 0xA5 to port 4. Required: ext_out[15:8] = 0xA5 next cycle. Drive ext_in[7:0] = 0x3C. Required: pat_in[3] = 0x3C the same cycle.
